div_8bits_seq: RTL and testbench
================================

Name: div_8bits_seq

Overview:
Multi-cycle 8-bit integer divider: the inverse operation of the team's combinational 8-bit multiplier (Prod = A*B, signed/unsigned).
- Computes Quot = A / B and Rem = A % B, unsigned or two's-complement signed, selected by Signed.
- Restoring, one quotient bit per clock, start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit.

Parameters:
WIDTH, 8, operand/quotient/remainder width; only 8 is verified.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when busy=0.
A  input  8  dividend; latched when start is accepted.
B  input  8  divisor; latched when start is accepted.
Signed  input  1  1 = two's-complement operands; latched with A/B.
Quot  output  8  quotient, registered, held until next completion.
Rem  output  8  remainder, registered, held until next completion.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse, result valid.
div_zero  output  1  divide-by-zero flag, updated with done (see Optional Feature).

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset (async, any time, including mid-operation):
  - state=IDLE.
  - Quot, Rem, busy, done, div_zero all 0.
  - Internal counter and working registers cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - busy=0.
  - start=1 at edge k: latch Signed; latch magnitudes |A| and |B| (magnitude = operand if Signed=0 or MSB=0, else ~x+1).
  - Record sign flags: qneg = Signed & (A[7]^B[7]); rneg = Signed & A[7].
  - Clear the 8-bit partial remainder; set cnt=0; go to CALC; busy=1 from edge k.
- CALC, edges k+1..k+8, one iteration each:
  - Shift {prem, dividend} left by 1.
  - trial = prem - |B| (9-bit).
  - If trial is non-negative: prem=trial and quotient bit=1; else quotient bit=0.
  - cnt increments; after the 8th iteration (edge k+8) go to FIX.
- FIX, edge k+9:
  - Quot = qneg ? -q : q; Rem = rneg ? -prem : prem.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
  - Latency: start edge to done visible = 9 clocks; throughput 1 op per 10 cycles.
- Division truncates toward zero; a nonzero remainder takes the sign of the dividend.
- -128 / -1 (signed): Quot=8'h80, Rem=8'h00. This wrap is the natural result and is not flagged.
- -128 magnitude: 8'h80 is handled as unsigned 128 inside the datapath.
- start while busy=1: ignored; latched operands are unaffected.
- start in the cycle done=1 (state IDLE): accepted normally.
- A, B, Signed changing during CALC/FIX: no effect.
- Quot/Rem change only at the FIX edge (or reset) and hold afterwards.

Optional Feature:
Macro DIV_ZERO_DETECT_EN.
- Defined:
  - On accept with B=0, go directly to FIX at edge k.
  - At edge k+1: Quot=8'hFF, Rem=A (raw latched dividend), div_zero=1, done=1, busy=0.
  - div_zero holds until the next completion, which clears it when B≠0.
- Undefined:
  - No B=0 detection; the normal 9-cycle flow runs and div_zero is tied 0.
  - Unsigned result: Quot=8'hFF, Rem=A.
  - Signed result: Quot=8'hFF if A≥0, 8'h01 if A<0; Rem=A.

Test Plan:
- Unsigned: A=200, B=7, Signed=0, start at edge k -> busy high edges k..k+8, done pulse after edge k+9, Quot=8'h1C, Rem=8'h04.
- Signed sign cases: -7/2 -> Quot=8'hFD, Rem=8'hFF; 7/-2 -> Quot=8'hFD, Rem=8'h01; -7/-2 -> Quot=8'h03, Rem=8'hFF.
- Overflow edge: A=8'h80, B=8'hFF, Signed=1 -> Quot=8'h80, Rem=8'h00, div_zero=0.
- Divide by zero: A=8'h35, B=0, Signed=0:
  - with DIV_ZERO_DETECT_EN -> done one edge after accept, Quot=8'hFF, Rem=8'h35, div_zero=1;
  - without it -> done after 9 clocks, same Quot/Rem, div_zero=0.
- Handshake: second start with new operands at edge k+3 -> ignored, first result correct; start again during the done cycle -> accepted, next done exactly 10 cycles after the previous one.
- Reset mid-operation: assert rst asynchronously at k+4 -> all outputs 0 immediately, no done pulse; after release a new 100/9 -> Quot=8'h0B, Rem=8'h01.

Source files
------------

// File: rtl/div_8bits_seq.sv
// div_8bits_seq: restoring divider that yields one quotient bit per clock, producing A/B and A%B.
// Operands are unsigned or two's-complement, selected by Signed.
// Latency: done appears 9 clocks after start is accepted, and the unit issues one op per 10 cycles.
// Backpressure: start is ignored while busy. Build with DIV_ZERO_DETECT_EN for a 1-cycle B==0 path and the div_zero flag.
module div_8bits_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The shifted partial remainder can reach 2*|B|-1, so it needs one extra bit.
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

`ifdef DIV_ZERO_DETECT_EN
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             dz_q, dz_d;
  logic             div_zero_q, div_zero_d;
`endif

  // Restoring step datapath: shift one dividend bit into the partial remainder, then trial-subtract.
  always_comb begin
    shifted = {prem_q, dvd_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, bmag_q});
    // When the subtraction fits, the result is below |B|, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - bmag_q;
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence and for the result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    bmag_d  = bmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    araw_d     = araw_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = (Signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
          bmag_d  = (Signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
          qneg_d  = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d  = Signed & A[WIDTH-1];
          prem_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
`ifdef DIV_ZERO_DETECT_EN
          araw_d = A;
          dz_d   = (B == '0);
          if (B == '0) state_d = S_FIX;
`endif
        end
      end
      S_CALC: begin
        prem_d = fits ? diff : shifted[WIDTH-1:0];
        dvd_d  = {dvd_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
        rem_d   = rneg_q ? (~prem_q + WIDTH'(1)) : prem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d = dz_q;
        if (dz_q) begin
          quot_d = '1;
          rem_d  = araw_q;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      bmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      araw_q     <= '0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      araw_q     <= araw_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign Quot = quot_q;
  assign Rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_8bits_seq.sv
// Scoreboard bench for div_8bits_seq: directed sign/overflow/zero cases, handshake, reset, random ops.
module tb_div_8bits_seq;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       sgn;
  logic [7:0] quot, rem;
  logic       busy, done, div_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] last_q = 8'h00;
  logic       prev_done = 1'b0;

  typedef struct packed {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic [31:0] acc;
    logic [31:0] lat;
  } ent_t;

  ent_t sb[$];

  div_8bits_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Signed(sgn),
    .Quot(quot), .Rem(rem), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model built from the language's own truncating division.
  function automatic ent_t model(input logic [7:0] av, input logic [7:0] bv, input logic s);
    ent_t e;
    int sa, sbv;
    logic [31:0] t;
    e = '0;
    if (bv == 8'h00) begin
      e.q   = DZ_EN ? 8'hFF : ((s && av[7]) ? 8'h01 : 8'hFF);
      e.r   = av;
      e.dz  = DZ_EN;
      e.lat = DZ_EN ? 32'd1 : 32'd9;
    end else begin
      if (s) begin
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        t   = 32'(sa / sbv);
        e.q = t[7:0];
        t   = 32'(sa % sbv);
        e.r = t[7:0];
      end else begin
        e.q = av / bv;
        e.r = av % bv;
      end
      e.lat = 32'd9;
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && done) begin
      if (prev_done) chk("done_width", 32'd2, 32'd1);
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quot", 32'(quot), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.r));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency", 32'(cyc) - e.acc, e.lat);
        last_q = e.q;
      end
    end
    prev_done = done;
  end

  // Called at a negedge: waits for idle, presents one request, returns at the negedge after acceptance.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic s);
    ent_t e;
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    a = av; b = bv; sgn = s; start = 1'b1;
    e = model(av, bv, s);
    e.acc = 32'(cyc + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  initial begin
    int d1, d2, n;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; sgn = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'd200, 8'd7, 1'b0);
    issue(8'hF9, 8'h02, 1'b1);   // -7 / 2
    issue(8'h07, 8'hFE, 1'b1);   //  7 / -2
    issue(8'hF9, 8'hFE, 1'b1);   // -7 / -2
    issue(8'h80, 8'hFF, 1'b1);   // -128 / -1 wraps
    issue(8'h35, 8'h00, 1'b0);   // divide by zero, unsigned
    issue(8'hC8, 8'h00, 1'b1);   // divide by zero, negative signed dividend
    issue(8'h80, 8'h80, 1'b0);   // 128 / 128 unsigned
    issue(8'hFF, 8'h01, 1'b0);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue(8'd50, 8'd3, 1'b0);
    @(negedge clk); @(negedge clk);
    a = 8'd1; b = 8'd1; sgn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d1);
    issue(8'd99, 8'd10, 1'b0);
    wait_done(d2);
    chk("done_gap", 32'(d2 - d1), 32'd10);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    issue(8'd123, 8'd5, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_quot", 32'(quot), 32'd0);
    chk("mid_rst_rem", 32'(rem), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dz", 32'(div_zero), 32'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'd100, 8'd9, 1'b0);

    for (int i = 0; i < 16; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_quot", 32'(quot), 32'(last_q));
    chk("idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
